// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - strobe bundle between the control unit (master) and the datapath (slave)
interface control_unit_if;
  logic [31:0] IR;
  logic        CON, Stop, Run;
  logic        PCout, ZHIout, ZLOout, MDRout, HIout, LOout, INPORTout, Cout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OUTPORTin, CONin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        Read, write, IncPC;

  modport master (
    input  IR, CON, Stop,
    output Run, PCout, ZHIout, ZLOout, MDRout, HIout, LOout, INPORTout, Cout,
           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OUTPORTin, CONin,
           Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC
  );

  modport slave (
    output IR, CON, Stop,
    input  Run, PCout, ZHIout, ZLOout, MDRout, HIout, LOout, INPORTout, Cout,
           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OUTPORTin, CONin,
           Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore sequencer: fetch F0-F3, opcode-specific E-steps, HALT
module control_unit (
  input  logic           Clock,
  input  logic           clr_n,
  control_unit_if.master bus
);
  typedef enum logic [3:0] {
    S_RESET, S_F0, S_F1, S_F2, S_F3,
    S_E1, S_E2, S_E3, S_E4, S_E5, S_E6, S_E7, S_E8, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MUL, C_NEG,
    C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
  } iclass_t;

  typedef struct packed {
    logic PCout, ZHIout, ZLOout, MDRout, HIout, LOout, INPORTout, Cout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OUTPORTin, CONin;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic Read, write, IncPC;
  } strobes_t;

  state_t   state_q, state_d;
  iclass_t  iclass;
  state_t   last_e;
  strobes_t strb;
  logic     in_exec;
  logic     unused_ir;

  assign unused_ir = ^bus.IR[26:0];
  assign in_exec   = (state_q >= S_E1) && (state_q <= S_E8);

  always_comb begin
    iclass = C_NOP;
    case (bus.IR[31:27]) inside
      [5'd3:5'd11]:  iclass = C_ALU;
      [5'd12:5'd14]: iclass = C_IMM;
      5'd1:          iclass = C_LDI;
      5'd0:          iclass = C_LD;
      5'd2:          iclass = C_ST;
      5'd15, 5'd16:  iclass = C_MUL;
      5'd17, 5'd18:  iclass = C_NEG;
      5'd19:         iclass = C_BR;
      5'd20:         iclass = C_JR;
      5'd21:         iclass = C_JAL;
      5'd22:         iclass = C_IN;
      5'd23:         iclass = C_OUT;
      5'd24:         iclass = C_MFHI;
      5'd25:         iclass = C_MFLO;
      5'd27:         iclass = C_HALT;
      default:       iclass = C_NOP;
    endcase
  end

  // Final step of each instruction; nop and undefined opcodes end at F3.
  always_comb begin
    last_e = S_F3;
    case (iclass)
      C_ALU, C_IMM, C_LDI:                last_e = S_E3;
      C_LD:                               last_e = S_E6;
      C_ST:                               last_e = S_E5;
      C_MUL, C_BR:                        last_e = S_E4;
      C_NEG, C_JAL:                       last_e = S_E2;
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO:  last_e = S_E1;
      default:                            last_e = S_F3;
    endcase
  end

  always_ff @(posedge Clock or negedge clr_n) begin
    if (!clr_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1:    state_d = S_F2;
      S_F2:    state_d = S_F3;
      S_HALT:  state_d = S_HALT;
      default: begin
        if (state_q == S_F3 && iclass == C_HALT) state_d = S_HALT;
        else if (state_q == last_e)              state_d = bus.Stop ? S_HALT : S_F0;
        else                                     state_d = state_t'(state_q + 4'd1);
      end
    endcase
  end

  always_comb begin
    strb = '0;
    case (state_q)
      S_F0: begin strb.PCout = 1'b1; strb.MARin = 1'b1; strb.IncPC = 1'b1; strb.Zin = 1'b1; end
      S_F1: begin strb.ZLOout = 1'b1; strb.PCin = 1'b1; strb.Read = 1'b1; end
      S_F2: begin strb.Read = 1'b1; strb.MDRin = 1'b1; end
      S_F3: begin strb.MDRout = 1'b1; strb.IRin = 1'b1; end
      default: ;
    endcase
    if (in_exec) begin
      case (iclass)
        C_ALU, C_IMM, C_LDI: begin
          case (state_q)
            S_E1: begin
              strb.Grb = 1'b1; strb.Yin = 1'b1;
              strb.Rout = (iclass != C_LDI); strb.BAout = (iclass == C_LDI);
            end
            S_E2: begin
              strb.Zin = 1'b1;
              if (iclass == C_ALU) begin strb.Grc = 1'b1; strb.Rout = 1'b1; end
              else                 strb.Cout = 1'b1;
            end
            S_E3: begin strb.ZLOout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
            default: ;
          endcase
        end
        C_LD, C_ST: begin
          case (state_q)
            S_E1: begin strb.Grb = 1'b1; strb.BAout = 1'b1; strb.Yin = 1'b1; end
            S_E2: begin strb.Cout = 1'b1; strb.Zin = 1'b1; end
            S_E3: begin strb.ZLOout = 1'b1; strb.MARin = 1'b1; end
            S_E4: begin
              if (iclass == C_LD) strb.Read = 1'b1;
              else begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.MDRin = 1'b1; end
            end
            S_E5: begin
              if (iclass == C_LD) begin strb.Read = 1'b1; strb.MDRin = 1'b1; end
              else strb.write = 1'b1;
            end
            S_E6: if (iclass == C_LD) begin strb.MDRout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
            default: ;
          endcase
        end
        C_MUL: begin
          case (state_q)
            S_E1: begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.Yin = 1'b1; end
            S_E2: begin strb.Grb = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1; end
            S_E3: begin strb.ZLOout = 1'b1; strb.LOin = 1'b1; end
            S_E4: begin strb.ZHIout = 1'b1; strb.HIin = 1'b1; end
            default: ;
          endcase
        end
        C_NEG: begin
          case (state_q)
            S_E1: begin strb.Grb = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1; end
            S_E2: begin strb.ZLOout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
            default: ;
          endcase
        end
        C_BR: begin
          case (state_q)
            S_E1: begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.CONin = 1'b1; end
            S_E2: begin strb.PCout = 1'b1; strb.Yin = 1'b1; end
            S_E3: begin strb.Cout = 1'b1; strb.Zin = 1'b1; end
            S_E4: begin strb.ZLOout = 1'b1; strb.PCin = bus.CON; end
            default: ;
          endcase
        end
        C_JAL: begin
          case (state_q)
            S_E1: begin strb.PCout = 1'b1; strb.Grb = 1'b1; strb.Rin = 1'b1; end
            S_E2: begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.PCin = 1'b1; end
            default: ;
          endcase
        end
        C_JR:   if (state_q == S_E1) begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.PCin = 1'b1; end
        C_IN:   if (state_q == S_E1) begin strb.INPORTout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
        C_OUT:  if (state_q == S_E1) begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.OUTPORTin = 1'b1; end
        C_MFHI: if (state_q == S_E1) begin strb.HIout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
        C_MFLO: if (state_q == S_E1) begin strb.LOout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
        default: ;
      endcase
    end
  end

  assign bus.Run = (state_q != S_RESET) && (state_q != S_HALT);
  assign {bus.PCout, bus.ZHIout, bus.ZLOout, bus.MDRout, bus.HIout, bus.LOout, bus.INPORTout, bus.Cout,
          bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin, bus.Zin, bus.HIin, bus.LOin, bus.OUTPORTin,
          bus.CONin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
          bus.Read, bus.write, bus.IncPC} = strb;
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - per-cycle strobe checks of control_unit against a step-table model
module tb_control_unit;
  logic Clock, clr_n;
  control_unit_if cu();

  control_unit dut (.Clock(Clock), .clr_n(clr_n), .bus(cu));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  localparam logic [27:0] PCOUT = 28'h1 << 0,  ZHIOUT = 28'h1 << 1,  ZLOOUT = 28'h1 << 2,  MDROUT = 28'h1 << 3;
  localparam logic [27:0] HIOUT = 28'h1 << 4,  LOOUT  = 28'h1 << 5,  INPORTOUT = 28'h1 << 6, COUT = 28'h1 << 7;
  localparam logic [27:0] PCIN  = 28'h1 << 8,  IRIN   = 28'h1 << 9,  MARIN  = 28'h1 << 10, MDRIN = 28'h1 << 11;
  localparam logic [27:0] YIN   = 28'h1 << 12, ZIN    = 28'h1 << 13, HIIN   = 28'h1 << 14, LOIN  = 28'h1 << 15;
  localparam logic [27:0] OUTPORTIN = 28'h1 << 16, CONIN = 28'h1 << 17, GRA = 28'h1 << 18, GRB = 28'h1 << 19;
  localparam logic [27:0] GRC   = 28'h1 << 20, RIN    = 28'h1 << 21, ROUT   = 28'h1 << 22, BAOUT = 28'h1 << 23;
  localparam logic [27:0] READ  = 28'h1 << 24, WRITE  = 28'h1 << 25, INCPC  = 28'h1 << 26, RUN   = 28'h1 << 27;

  logic [27:0] obs;
  assign obs = {cu.Run, cu.IncPC, cu.write, cu.Read, cu.BAout, cu.Rout, cu.Rin, cu.Grc, cu.Grb, cu.Gra,
                cu.CONin, cu.OUTPORTin, cu.LOin, cu.HIin, cu.Zin, cu.Yin, cu.MDRin, cu.MARin, cu.IRin,
                cu.PCin, cu.Cout, cu.INPORTout, cu.LOout, cu.HIout, cu.MDRout, cu.ZLOout, cu.ZHIout, cu.PCout};

  int errors = 0;
  int checks = 0;
  logic [27:0] exp_q[$];

  task automatic chk(input string tag, input logic [27:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected strobe set for every step of one instruction, fetch included.
  function automatic void build(input logic [4:0] op, input logic con);
    logic [27:0] ex[$];
    exp_q.delete();
    case (op) inside
      [5'd3:5'd11]:  ex = '{GRB|ROUT|YIN, GRC|ROUT|ZIN, ZLOOUT|GRA|RIN};
      [5'd12:5'd14]: ex = '{GRB|ROUT|YIN, COUT|ZIN, ZLOOUT|GRA|RIN};
      5'd1:          ex = '{GRB|BAOUT|YIN, COUT|ZIN, ZLOOUT|GRA|RIN};
      5'd0:          ex = '{GRB|BAOUT|YIN, COUT|ZIN, ZLOOUT|MARIN, READ, READ|MDRIN, MDROUT|GRA|RIN};
      5'd2:          ex = '{GRB|BAOUT|YIN, COUT|ZIN, ZLOOUT|MARIN, GRA|ROUT|MDRIN, WRITE};
      5'd15, 5'd16:  ex = '{GRA|ROUT|YIN, GRB|ROUT|ZIN, ZLOOUT|LOIN, ZHIOUT|HIIN};
      5'd17, 5'd18:  ex = '{GRB|ROUT|ZIN, ZLOOUT|GRA|RIN};
      5'd19:         ex = '{GRA|ROUT|CONIN, PCOUT|YIN, COUT|ZIN, ZLOOUT | (con ? PCIN : 28'h0)};
      5'd20:         ex = '{GRA|ROUT|PCIN};
      5'd21:         ex = '{PCOUT|GRB|RIN, GRA|ROUT|PCIN};
      5'd22:         ex = '{INPORTOUT|GRA|RIN};
      5'd23:         ex = '{GRA|ROUT|OUTPORTIN};
      5'd24:         ex = '{HIOUT|GRA|RIN};
      5'd25:         ex = '{LOOUT|GRA|RIN};
      default:       ex = {};
    endcase
    exp_q.push_back(RUN|PCOUT|MARIN|INCPC|ZIN);
    exp_q.push_back(RUN|ZLOOUT|PCIN|READ);
    exp_q.push_back(RUN|READ|MDRIN);
    exp_q.push_back(RUN|MDROUT|IRIN);
    foreach (ex[i]) exp_q.push_back(RUN | ex[i]);
  endfunction

  // Entered #1 after the edge into F0; returns #1 after the edge leaving the last step.
  task automatic run_instr(input logic [4:0] op, input logic con, input logic mid_stop, input logic end_stop);
    build(op, con);
    cu.IR   = {op, 27'($urandom)};
    cu.CON  = con;
    cu.Stop = mid_stop;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == exp_q.size() - 1) cu.Stop = end_stop;
      chk($sformatf("op%0d_con%0d_step%0d", op, con, i), exp_q[i]);
      @(posedge Clock); #1;
    end
    cu.Stop = 1'b0;
  endtask

  task automatic halt_hold(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cu.Stop = 1'($urandom);
      cu.CON  = 1'($urandom);
      cu.IR   = $urandom;
      chk($sformatf("%s_halt%0d", tag, i), 28'h0);
      @(posedge Clock); #1;
    end
    cu.Stop = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #2 clr_n = 1'b0;
    #1 chk({tag, "_async"}, 28'h0);
    @(posedge Clock); #1;
    chk({tag, "_hold"}, 28'h0);
    #2 clr_n = 1'b1;
    @(posedge Clock); #1;
  endtask

  initial begin
    logic [4:0] op;
    clr_n   = 1'b0;
    cu.IR   = '0;
    cu.CON  = 1'b0;
    cu.Stop = 1'b0;
    #2 chk("por", 28'h0);
    @(posedge Clock); #1;
    chk("por_hold", 28'h0);
    #2 clr_n = 1'b1;
    @(posedge Clock); #1;

    run_instr(5'd3, 1'b0, 1'b0, 1'b0);
    run_instr(5'd0, 1'b0, 1'b0, 1'b0);
    run_instr(5'd2, 1'b0, 1'b0, 1'b0);
    run_instr(5'd19, 1'b1, 1'b0, 1'b0);
    run_instr(5'd19, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++)
      if (k != 27) run_instr(5'(k), 1'($urandom), 1'b0, 1'b0);

    run_instr(5'd3, 1'b0, 1'b1, 1'b1);
    halt_hold("stop", 20);
    do_reset("rst_after_stop");

    run_instr(5'd27, 1'b0, 1'b0, 1'b0);
    halt_hold("halt_op", 20);
    do_reset("rst_after_halt");

    // Abort ld in E4 while Read is high.
    build(5'd0, 1'b0);
    cu.IR  = {5'd0, 27'($urandom)};
    cu.CON = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ld_abort_step%0d", i), exp_q[i]);
      if (i < 7) begin @(posedge Clock); #1; end
    end
    do_reset("ld_e4");
    run_instr(5'd0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(31, 0));
      if (op == 5'd27) op = 5'd26;
      run_instr(op, 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
